// File: rtl/top_encoder_display_pkg.sv
// Shared definitions for the encoder-driven 4-digit counter display.
// Holds the counter and BCD widths, the 7-segment patterns and the
// digit-to-segment lookup used by top_encoder_display.
package top_encoder_display_pkg;

    localparam int unsigned COUNT_W    = 14;
    localparam int unsigned COUNT_MAX  = 9999;
    localparam int unsigned BCD_W      = 4;
    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned BCD_ALL_W  = BCD_W * NUM_DIGITS;
    localparam int unsigned SEG_W      = 8;
    localparam int unsigned CATH_W     = NUM_DIGITS;

    // Segment order {DP,G,F,E,D,C,B,A}, active-high, DP off
    localparam logic [SEG_W-1:0] SEG_0     = 8'h3F;
    localparam logic [SEG_W-1:0] SEG_1     = 8'h06;
    localparam logic [SEG_W-1:0] SEG_2     = 8'h5B;
    localparam logic [SEG_W-1:0] SEG_3     = 8'h4F;
    localparam logic [SEG_W-1:0] SEG_4     = 8'h66;
    localparam logic [SEG_W-1:0] SEG_5     = 8'h6D;
    localparam logic [SEG_W-1:0] SEG_6     = 8'h7D;
    localparam logic [SEG_W-1:0] SEG_7     = 8'h07;
    localparam logic [SEG_W-1:0] SEG_8     = 8'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 8'h6F;
    localparam logic [SEG_W-1:0] SEG_BLANK = 8'h00;

    // Map one BCD digit to its segment pattern; non-decimal codes go dark
    function automatic logic [SEG_W-1:0] digit_to_seg(input logic [BCD_W-1:0] digit);
        logic [SEG_W-1:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/top_encoder_display_double_dabble.sv
// Combinational binary-to-BCD converter (shift-add-3 / double dabble).
// Ports:
//   i_bin  [INPUT_W-1:0]  binary input
//   o_bcd  [15:0]         packed BCD {thousands, hundreds, tens, units}
// Inputs above 9999 overflow the four-digit result and are truncated.
module double_dabble
    import top_encoder_display_pkg::*;
#(
    parameter int unsigned INPUT_W = 14
) (
    input  logic [INPUT_W-1:0]   i_bin,
    output logic [BCD_ALL_W-1:0] o_bcd
);

    localparam int unsigned SR_W = BCD_ALL_W + INPUT_W;

    logic [SR_W-1:0] w_sr;

    // Binary sits in the low bits; each pass corrects BCD nibbles then shifts left
    always_comb begin
        w_sr = '0;
        w_sr[INPUT_W-1:0] = i_bin;
        for (int unsigned i = 0; i < INPUT_W; i++) begin
            for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
                if (w_sr[INPUT_W + BCD_W*d +: BCD_W] >= 4'd5) begin
                    w_sr[INPUT_W + BCD_W*d +: BCD_W] = w_sr[INPUT_W + BCD_W*d +: BCD_W] + 4'd3;
                end
            end
            w_sr = w_sr << 1;
        end
        o_bcd = w_sr[INPUT_W +: BCD_ALL_W];
    end

endmodule

// File: rtl/top_encoder_display.sv
// Board top: quadrature encoder -> 0..9999 wrapping counter -> BCD ->
// multiplexed common-cathode 4-digit 7-segment display.
// Ports:
//   Clock       system clock, rising edge
//   Reset       asynchronous active-low reset
//   EncoderA_i  encoder channel A (asynchronous, idle high)
//   EncoderB_i  encoder channel B (asynchronous, idle high)
//   Cathodes_o  [3:0] digit select, active-low one-hot, bit0 = units
//   Segments_o  [7:0] segments {DP,G,F,E,D,C,B,A}, active-high
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module top_encoder_display
    import top_encoder_display_pkg::*;
#(
    parameter int unsigned CLOCK_HZ = 10_000_000,
    parameter int unsigned DIGIT_HZ = 1_000
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              EncoderA_i,
    input  logic              EncoderB_i,
    output logic [CATH_W-1:0] Cathodes_o,
    output logic [SEG_W-1:0]  Segments_o
);

    localparam int unsigned DIV_RAW = CLOCK_HZ / DIGIT_HZ;
    localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned TIMER_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(DIV - 1);
    localparam logic [COUNT_W-1:0] COUNT_TOP  = COUNT_W'(COUNT_MAX);

    logic                 r_a_s1, r_a_s2, r_a_d;
    logic                 r_b_s1, r_b_s2;
    logic [COUNT_W-1:0]   r_count;
    logic [TIMER_W-1:0]   r_timer;
    logic [1:0]           r_index;
    logic                 w_a_fall;
    logic [BCD_ALL_W-1:0] w_bcd;
    logic [BCD_W-1:0]     w_digit;
    logic [NUM_DIGITS-1:0] w_blank;
    logic [SEG_W-1:0]     w_seg;

    // One count per detent: only a synchronized falling edge of A counts
    assign w_a_fall = r_a_d & ~r_a_s2;

    // Two-flop synchronizers, A edge register and the wrapping counter
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_a_s1  <= 1'b1;
            r_a_s2  <= 1'b1;
            r_a_d   <= 1'b1;
            r_b_s1  <= 1'b1;
            r_b_s2  <= 1'b1;
            r_count <= '0;
        end else begin
            r_a_s1 <= EncoderA_i;
            r_a_s2 <= r_a_s1;
            r_a_d  <= r_a_s2;
            r_b_s1 <= EncoderB_i;
            r_b_s2 <= r_b_s1;
            if (w_a_fall) begin
                if (r_b_s2) begin
                    r_count <= (r_count == COUNT_TOP) ? '0 : r_count + COUNT_W'(1);
                end else begin
                    r_count <= (r_count == '0) ? COUNT_TOP : r_count - COUNT_W'(1);
                end
            end
        end
    end

    double_dabble #(
        .INPUT_W (COUNT_W)
    ) u_double_dabble (
        .i_bin (r_count),
        .o_bcd (w_bcd)
    );

    assign w_digit = w_bcd[{r_index, 2'b00} +: BCD_W];

`ifdef LEADING_ZERO_BLANK_EN
    // A digit goes dark only if it and every digit above it are zero
    always_comb begin
        w_blank    = '0;
        w_blank[3] = (w_bcd[15:12] == 4'd0);
        w_blank[2] = w_blank[3] && (w_bcd[11:8] == 4'd0);
        w_blank[1] = w_blank[2] && (w_bcd[7:4] == 4'd0);
    end
`else
    assign w_blank = '0;
`endif

    assign w_seg = w_blank[r_index] ? SEG_BLANK : digit_to_seg(w_digit);

    // Scan: r_index names the digit shown at the next terminal count, so the
    // display stays dark after reset until the first terminal count shows digit 0
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_timer    <= '0;
            r_index    <= '0;
            Cathodes_o <= '1;
            Segments_o <= SEG_BLANK;
        end else begin
            if (r_timer == TIMER_LAST) begin
                r_timer    <= '0;
                r_index    <= r_index + 2'd1;
                Cathodes_o <= ~(4'b0001 << r_index);
                Segments_o <= w_seg;
            end else begin
                r_timer <= r_timer + TIMER_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_top_encoder_display.sv
`timescale 1ns/1ps
module tb_top_encoder_display;
    import top_encoder_display_pkg::*;

    logic       Clock;
    logic       Reset;
    logic       EncoderA_i;
    logic       EncoderB_i;
    logic [3:0] Cathodes_o;
    logic [7:0] Segments_o;

    logic [13:0] dd_bin;
    logic [15:0] dd_bcd;

    int total;
    int bad;

    top_encoder_display #(
        .CLOCK_HZ (1_000_000),
        .DIGIT_HZ (1_000)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .EncoderA_i (EncoderA_i),
        .EncoderB_i (EncoderB_i),
        .Cathodes_o (Cathodes_o),
        .Segments_o (Segments_o)
    );

    double_dabble #(.INPUT_W(14)) u_dd_ref (
        .i_bin (dd_bin),
        .o_bcd (dd_bcd)
    );

    initial Clock = 1'b0;
    always #500 Clock = ~Clock;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [7:0] LZ = 8'h00;
`else
    localparam logic [7:0] LZ = 8'h3F;
`endif

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic settle();
        repeat (10) tick();
    endtask

    task automatic enc_inc();
        EncoderA_i = 1'b0; settle();
        EncoderB_i = 1'b0; settle();
        EncoderA_i = 1'b1; settle();
        EncoderB_i = 1'b1; settle();
    endtask

    task automatic enc_dec();
        EncoderB_i = 1'b0; settle();
        EncoderA_i = 1'b0; settle();
        EncoderB_i = 1'b1; settle();
        EncoderA_i = 1'b1; settle();
    endtask

    // Wait until digit idx is selected, return its segments; bounded
    task automatic wait_digit(input int idx, output logic [7:0] seg, output bit timed_out);
        logic [3:0] want;
        want = ~(4'b0001 << idx);
        timed_out = 1'b1;
        seg = 8'hxx;
        for (int n = 0; n < 5000; n++) begin
            tick();
            if (Cathodes_o === want) begin
                seg = Segments_o;
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic check_digits(input string name, input logic [7:0] exp0, input logic [7:0] exp1,
                                input logic [7:0] exp2, input logic [7:0] exp3);
        logic [7:0] exp_arr [4];
        logic [7:0] seg;
        bit to;
        exp_arr[0] = exp0; exp_arr[1] = exp1; exp_arr[2] = exp2; exp_arr[3] = exp3;
        for (int d = 0; d < 4; d++) begin
            wait_digit(d, seg, to);
            total++;
            if (to || seg !== exp_arr[d]) begin
                bad++;
                $display("FAIL %s digit%0d: got seg=%h timeout=%0d, expected %h", name, d, seg, to, exp_arr[d]);
            end
        end
    endtask

    task automatic check_count(input string name, input int exp);
        total++;
        if (dut.r_count !== 14'(exp)) begin
            bad++;
            $display("FAIL %s: count=%0d expected %0d", name, dut.r_count, exp);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0; EncoderA_i = 1'b1; EncoderB_i = 1'b1;
        repeat (5) tick();
        total++;
        if (Cathodes_o !== 4'b1111) begin bad++; $display("FAIL reset_cath: got %b expected 1111", Cathodes_o); end
        total++;
        if (Segments_o !== 8'h00) begin bad++; $display("FAIL reset_seg: got %h expected 00", Segments_o); end
        check_count("reset_count", 0);
        Reset = 1'b1;
        tick();
        total++;
        if (Cathodes_o !== 4'b1111) begin bad++; $display("FAIL post_reset_cath: got %b expected 1111", Cathodes_o); end
    endtask

    task automatic test_latency();
        EncoderA_i = 1'b0;
        tick(); tick();
        check_count("latency_2edges", 0);
        tick();
        check_count("latency_3edges", 1);
        settle();
        EncoderB_i = 1'b0; settle();
        EncoderA_i = 1'b1; settle();
        EncoderB_i = 1'b1; settle();
        check_count("latency_full_detent", 1);
    endtask

    task automatic test_increment();
        repeat (9) enc_inc();
        check_count("inc_to_10", 10);
        check_digits("inc_10", 8'h3F, 8'h06, LZ, LZ);
    endtask

    task automatic test_decrement();
        repeat (10) enc_dec();
        check_count("dec_to_0", 0);
        repeat (10) enc_dec();
        check_count("dec_wrap_9990", 9990);
        check_digits("dec_9990", 8'h3F, 8'h6F, 8'h6F, 8'h6F);
    endtask

    task automatic test_wrap();
        repeat (9) enc_inc();
        check_count("inc_to_9999", 9999);
        enc_inc();
        check_count("inc_wrap_0", 0);
        enc_dec();
        check_count("dec_wrap_9999", 9999);
        enc_inc();
        check_count("inc_wrap_0_again", 0);
    endtask

    task automatic test_blank();
        repeat (7) enc_inc();
        check_count("inc_to_7", 7);
        check_digits("count_7", 8'h07, LZ, LZ, LZ);
    endtask

    task automatic test_mux_timing();
        logic [3:0] exp_seq [5];
        int n;
        exp_seq[0] = 4'b1110; exp_seq[1] = 4'b1101; exp_seq[2] = 4'b1011;
        exp_seq[3] = 4'b0111; exp_seq[4] = 4'b1110;
        tick();
        Reset = 1'b0;
        repeat (3) tick();
        total++;
        if (Cathodes_o !== 4'b1111 || Segments_o !== 8'h00) begin
            bad++; $display("FAIL midscan_reset: cath=%b seg=%h expected 1111/00", Cathodes_o, Segments_o);
        end
        Reset = 1'b1;
        for (int s = 0; s < 5; s++) begin
            logic [3:0] prev;
            prev = Cathodes_o;
            n = 0;
            while (Cathodes_o === prev && n < 2000) begin
                tick();
                n++;
            end
            total++;
            if (n != 1000 || Cathodes_o !== exp_seq[s]) begin
                bad++;
                $display("FAIL mux_step%0d: cath=%b after %0d cycles, expected %b after 1000", s, Cathodes_o, n, exp_seq[s]);
            end
        end
        check_count("mux_count_reset", 0);
        check_digits("count_0", 8'h3F, LZ, LZ, LZ);
    endtask

    task automatic test_double_dabble();
        logic [15:0] exp;
        for (int v = 0; v <= 9999; v++) begin
            dd_bin = 14'(v);
            exp = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
            #1;
            total++;
            if (dd_bcd !== exp) begin
                bad++;
                $display("FAIL dd_%0d: got %h expected %h", v, dd_bcd, exp);
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        dd_bin = '0;
        Reset = 1'b0;
        EncoderA_i = 1'b1;
        EncoderB_i = 1'b1;
        test_reset();
        test_latency();
        test_increment();
        test_decrement();
        test_wrap();
        test_blank();
        test_mux_timing();
        test_double_dabble();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
